// File: rtl/revaluate_slice_controller_pkg.sv
// Shared constants and state encoding for the revaluate slice sequencer.
//   NUM_PAGE / NUM_TURNS : pages per state and turns per encode run
//   PAGE_BITS / TURN_BITS: counter and address widths
//   state_t              : 3-bit sequencer state encoding
package revaluate_slice_controller_pkg;

    localparam int unsigned NUM_PAGE   = 64;
    localparam int unsigned NUM_TURNS  = 24;
    localparam int unsigned PAGE_BITS  = 6;
    localparam int unsigned TURN_BITS  = 5;
    localparam int unsigned STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/revaluate_counter.sv
// Parameterised wrapping up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (same effect as rst)
//   en       : count enable; wraps MAX -> 0
//   q        : registered count
//   tc_c     : combinational terminal-count flag (q == MAX)
module revaluate_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned MAX   = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc_c
);

    assign tc_c = (q == WIDTH'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= tc_c ? '0 : q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/revaluate_slice_controller.sv
// Sequencer for the revaluate step: for each turn, reads every page into the
// slice register and writes the datapath result back to the same page.
//   clk, rst     : clock, synchronous active-high reset
//   start        : run request, honoured only in IDLE
//   mem_rd_valid : page memory read data valid, honoured only in WAIT
//   busy, done   : run in progress / one-cycle end-of-run pulse
//   mem_addr     : current page
//   mem_rd_en    : read strobe (READ), mem_wr_en: write-back strobe (WRITE)
//   reg_ld       : slice register load, same cycle as accepted read data
//   reg_clr      : slice register clear, same cycle as accepted start
//   turn         : current turn index for round-constant selection
module revaluate_slice_controller
    import revaluate_slice_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mem_rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic [PAGE_BITS-1:0] mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic                 reg_ld,
    output logic                 reg_clr,
    output logic [TURN_BITS-1:0] turn
);

    state_t state;

    logic start_acc_c;
    logic in_write_c;
    logic page_tc_c;
    logic turn_tc_c;
    logic last_c;

    // reg_ld / reg_clr must act in the cycle their input is seen, so they are
    // decoded from the current state; reset suppresses both.
    assign start_acc_c = !rst && (state == S_IDLE) && start;
    assign reg_clr     = start_acc_c;
    assign reg_ld      = !rst && (state == S_WAIT) && mem_rd_valid;

    assign in_write_c  = (state == S_WRITE);
    assign last_c      = page_tc_c && turn_tc_c;

    // Page counter doubles as mem_addr; it holds the last page after the run.
    revaluate_counter #(
        .WIDTH (PAGE_BITS),
        .MAX   (NUM_PAGE - 1)
    ) u_page_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc_c),
        .en   (in_write_c && !last_c),
        .q    (mem_addr),
        .tc_c (page_tc_c)
    );

    // Turn advances on the last page's write; it never wraps past the final turn.
    revaluate_counter #(
        .WIDTH (TURN_BITS),
        .MAX   (NUM_TURNS - 1)
    ) u_turn_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc_c),
        .en   (in_write_c && page_tc_c && !turn_tc_c),
        .q    (turn),
        .tc_c (turn_tc_c)
    );

    // Sequencer; registered outputs are set for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
        end else begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_READ;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                    busy  <= 1'b1;
                end
                S_WAIT: begin
                    busy <= 1'b1;
                    if (mem_rd_valid) begin
                        state     <= S_WRITE;
                        mem_wr_en <= 1'b1;
                    end
                end
                S_WRITE: begin
                    busy <= 1'b1;
                    if (last_c) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= S_READ;
                        mem_rd_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_revaluate_slice_controller.sv
// Self-checking bench: page-by-page expected waveform derived from the
// turn/page walk order and per-page stall schedule, with random noise on
// ignored inputs.
module tb_revaluate_slice_controller;
    import revaluate_slice_controller_pkg::*;

    localparam int unsigned TOTAL = NUM_PAGE * NUM_TURNS;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b1;
    logic                 mem_rd_valid = 1'b0;
    logic                 busy;
    logic                 done;
    logic [PAGE_BITS-1:0] mem_addr;
    logic                 mem_rd_en;
    logic                 mem_wr_en;
    logic                 reg_ld;
    logic                 reg_clr;
    logic [TURN_BITS-1:0] turn;

    int checks = 0;
    int failures = 0;
    int stall_q[TOTAL];
    int hold_page = 0;
    int hold_turn = 0;
    int n_ld, n_wr, n_done;

    revaluate_slice_controller dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mem_rd_valid (mem_rd_valid),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .reg_ld       (reg_ld),
        .reg_clr      (reg_clr),
        .turn         (turn)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_exp(input bit b, input bit d, input bit rd, input bit wr,
                                             input bit ld, input bit clr, input int addr, input int tn);
        return {15'd0, b, d, rd, wr, ld, clr, 6'(addr), 5'(tn)};
    endfunction

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs just after the edge, compare at the falling edge.
    task automatic step(input bit r, input bit s, input bit v, input logic [31:0] exp, input string tag);
        logic [31:0] obs;
        @(posedge clk);
        #1;
        rst = r;
        start = s;
        mem_rd_valid = v;
        @(negedge clk);
        obs = {15'd0, busy, done, mem_rd_en, mem_wr_en, reg_ld, reg_clr, mem_addr, turn};
        check_eq(tag, obs, exp);
        if (reg_ld === 1'b1) n_ld++;
        if (mem_wr_en === 1'b1) n_wr++;
        if (done === 1'b1) n_done++;
    endtask

    // One encode run starting from IDLE; abort_k >= 0 resets in that page's first WAIT cycle.
    task automatic run_once(input int abort_k, input bit noise, input string name);
        int p, t;
        n_ld = 0;
        n_wr = 0;
        n_done = 0;
        step(0, 1, noise ? rnd_bit() : 1'b0, pack_exp(0, 0, 0, 0, 0, 1, hold_page, hold_turn),
             {name, " start"});
        for (int k = 0; k < int'(TOTAL); k++) begin
            p = k % int'(NUM_PAGE);
            t = k / int'(NUM_PAGE);
            step(0, noise ? rnd_bit() : 1'b0, noise ? rnd_bit() : 1'b0,
                 pack_exp(1, 0, 1, 0, 0, 0, p, t), $sformatf("%s k%0d read", name, k));
            if (k == abort_k) begin
                step(1, 0, 0, pack_exp(1, 0, 0, 0, 0, 0, p, t), $sformatf("%s k%0d abort", name, k));
                hold_page = 0;
                hold_turn = 0;
                step(0, 0, 0, pack_exp(0, 0, 0, 0, 0, 0, 0, 0), {name, " post_abort"});
                check_eq({name, " ld_count"}, 32'(n_ld), 32'(k));
                check_eq({name, " wr_count"}, 32'(n_wr), 32'(k));
                check_eq({name, " done_count"}, 32'(n_done), 32'd0);
                return;
            end
            for (int s = 0; s < stall_q[k]; s++) begin
                step(0, noise ? rnd_bit() : 1'b0, 0, pack_exp(1, 0, 0, 0, 0, 0, p, t),
                     $sformatf("%s k%0d stall%0d", name, k, s));
            end
            step(0, noise ? rnd_bit() : 1'b0, 1, pack_exp(1, 0, 0, 0, 1, 0, p, t),
                 $sformatf("%s k%0d load", name, k));
            step(0, noise ? rnd_bit() : 1'b0, noise ? rnd_bit() : 1'b0,
                 pack_exp(1, 0, 0, 1, 0, 0, p, t), $sformatf("%s k%0d write", name, k));
        end
        step(0, noise, noise ? rnd_bit() : 1'b0,
             pack_exp(1, 1, 0, 0, 0, 0, NUM_PAGE - 1, NUM_TURNS - 1), {name, " done"});
        hold_page = int'(NUM_PAGE) - 1;
        hold_turn = int'(NUM_TURNS) - 1;
        check_eq({name, " ld_count"}, 32'(n_ld), 32'(TOTAL));
        check_eq({name, " wr_count"}, 32'(n_wr), 32'(TOTAL));
        check_eq({name, " done_count"}, 32'(n_done), 32'd1);
    endtask

    initial begin
        // Reset held with start high: everything stays quiet.
        @(posedge clk);
        step(1, 1, 1, pack_exp(0, 0, 0, 0, 0, 0, 0, 0), "reset0");
        step(1, 1, 1, pack_exp(0, 0, 0, 0, 0, 0, 0, 0), "reset1");
        // Spurious read-valid while idle.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, pack_exp(0, 0, 0, 0, 0, 0, 0, 0), $sformatf("idle_valid%0d", i));
        end

        // Run A: memory answers one cycle after the read strobe.
        foreach (stall_q[i]) stall_q[i] = 0;
        run_once(-1, 1'b0, "runA");

        // Run B: started in the IDLE right after DONE, stall on turn 0 page 5, input noise.
        stall_q[5] = 3;
        run_once(-1, 1'b1, "runB");
        step(0, 0, 1, pack_exp(0, 0, 0, 0, 0, 0, hold_page, hold_turn), "idle_after_B");

        // Run C: random stalls, reset during WAIT of turn 3 page 17.
        foreach (stall_q[i]) stall_q[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        run_once(3 * int'(NUM_PAGE) + 17, 1'b1, "runC");

        // Run D: full run after the abort, random stalls and noise.
        run_once(-1, 1'b1, "runD");
        step(0, 0, 1, pack_exp(0, 0, 0, 0, 0, 0, hold_page, hold_turn), "idle_after_D");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/revaluate_slice_controller.md
Name: revaluate_slice_controller

Overview:
Sequencer for the revaluate step of the matrix encoder. The 1600-cell state lives in a page memory of 64 pages, each page one 25-bit 5x5 slice. For each of 24 turns the block walks all 64 pages in order. Per page it reads the slice into the 25-bit slice register, then writes the datapath result back to the same page. It owns the memory address, the read/write strobes, the register load/clear and the current turn index used for round-constant selection.

Parameters:
NUM_PAGE, 64, pages per state (one 25-bit slice each)
NUM_TURNS, 24, turns per encode run
PAGE_BITS, 6, width of page counter / mem_addr
TURN_BITS, 5, width of turn counter / turn output

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset
start  in  1  request a full run; sampled only in IDLE
mem_rd_valid  in  1  read data valid from page memory; sampled only in WAIT
busy  out  1  high from first cycle after accepted start until DONE inclusive
done  out  1  one-cycle pulse at end of run
mem_addr  out  PAGE_BITS  page being read/written
mem_rd_en  out  1  read strobe, one cycle per page
mem_wr_en  out  1  write-back strobe, one cycle per page
reg_ld  out  1  load enable of slice register
reg_clr  out  1  synchronous clear of slice register
turn  out  TURN_BITS  current turn index 0..NUM_TURNS-1

Behaviour:
- Reset: rst, clk, synchronous, active-high. rst wins over all inputs. Next state IDLE. page=0, turn=0. All outputs 0.
- rst asserted mid-run aborts immediately. No further strobes after the reset edge. Memory contents are left as-is.
- States: IDLE, READ, WAIT, WRITE, DONE; 3-bit encoding.
- IDLE:
  - busy=0.
  - start=1 -> READ. Clear page and turn. Pulse reg_clr for that one cycle (the cycle start is sampled).
- READ:
  - mem_rd_en=1, mem_addr=page.
  - Always -> WAIT.
- WAIT:
  - mem_addr holds page.
  - Stays until mem_rd_valid=1; stall length is unbounded.
  - When mem_rd_valid=1: reg_ld=1 in that same cycle (register captures memory data) -> WRITE.
- WRITE:
  - mem_wr_en=1, mem_addr=page. The memory captures the datapath output derived from the register.
  - page<NUM_PAGE-1: page+1 -> READ.
  - page=NUM_PAGE-1 and turn<NUM_TURNS-1: page wraps to 0, turn+1 -> READ.
  - page=NUM_PAGE-1 and turn=NUM_TURNS-1 -> DONE.
- DONE:
  - done=1, busy=1 for exactly one cycle -> IDLE.
  - turn holds NUM_TURNS-1 until the next start.
- Strobe exclusivity: mem_rd_en, mem_wr_en and reg_ld are mutually exclusive and never high outside READ/WAIT/WRITE respectively.
- Ignored inputs:
  - mem_rd_valid outside WAIT.
  - start outside IDLE, including the DONE cycle; no queuing.
- Latency: with mem_rd_valid in the cycle after mem_rd_en, each page takes 3 cycles. done is high in cycle 4609 counting the start-sampling edge as cycle 0 (64*24*3 = 4608 page cycles, then DONE).
- Counters:
  - page and turn are unsigned.
  - turn never exceeds NUM_TURNS-1.
  - page wraps 63->0 only via the WRITE transition.

Decomposition:
- Shared package/defines file holds:
  - NUM_PAGE, NUM_TURNS, PAGE_BITS, TURN_BITS.
  - State encodings S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE; 3-bit state width.
- One natural sub-module: revaluate_counter, a parameterised up-counter with sync clr, en and terminal-count flag.
  - Instantiate twice: page counter and turn counter.
  - Turn counter enable = page terminal count AND WRITE.

Test Plan:
1. Reset: hold rst 2 cycles with start=1 -> all outputs 0, state IDLE, no strobes.
2. Full run, memory answers valid 1 cycle after rd_en:
   - done pulses at cycle 4609 with busy=1 in that cycle.
   - Exactly 1536 mem_wr_en and 1536 reg_ld pulses.
   - mem_addr sequence 0..63 repeated 24 times.
   - turn increments right after each page-63 write, ending at 23.
3. Stall: delay mem_rd_valid 3 extra cycles on turn 0 page 5 -> no reg_ld or mem_wr_en during the stall, page stays 5, done at cycle 4612.
4. start pulsed during the run and in the DONE cycle -> ignored, done pulse count 1. start in the following IDLE cycle -> new run from page 0, turn 0.
5. rst asserted at turn 3 page 17 during WAIT -> next cycle IDLE, all outputs 0. Subsequent start gives first mem_rd_en with mem_addr=0, turn=0.
6. Spurious mem_rd_valid in IDLE, READ, WRITE and DONE -> no reg_ld, no state change.
